// File: rtl/icache_direct.sv
// icache_direct: direct-mapped, one-word-per-block instruction cache with zero-latency hits.
// Optional ICACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module icache_direct #(
    parameter int INDEX_BITS = 4,
    parameter int WORD_W     = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              imemREN,
    input  logic [WORD_W-1:0] imemaddr,
    output logic              ihit,
    output logic [WORD_W-1:0] imemload,
    input  logic              flush,
    output logic              iREN,
    output logic [WORD_W-1:0] iaddr,
    input  logic              iwait,
    input  logic [WORD_W-1:0] iload
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);
    localparam int SETS  = 1 << INDEX_BITS;
    localparam int TAG_W = WORD_W - INDEX_BITS - 2;

    typedef enum logic {IDLE, FETCH} state_t;
    state_t r_state, w_next;

    logic [SETS-1:0]       r_valid;
    logic [TAG_W-1:0]      r_tag  [SETS];
    logic [WORD_W-1:0]     r_data [SETS];
    logic [WORD_W-1:0]     r_miss_addr;
    logic [INDEX_BITS-1:0] w_index, w_fill_index;
    logic [TAG_W-1:0]      w_tag, w_fill_tag;
    logic                  w_hit, w_miss, w_fill, w_unused;

    assign w_index      = imemaddr[INDEX_BITS+1:2];
    assign w_tag        = imemaddr[WORD_W-1:INDEX_BITS+2];
    assign w_fill_index = r_miss_addr[INDEX_BITS+1:2];
    assign w_fill_tag   = r_miss_addr[WORD_W-1:INDEX_BITS+2];
    assign w_unused     = ^imemaddr[1:0];
    assign w_hit        = imemREN && r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_miss       = (r_state == IDLE) && imemREN && !w_hit && !flush;
    assign w_fill       = (r_state == FETCH) && !iwait;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE) w_next = w_miss ? FETCH : IDLE;
        else                 w_next = iwait ? FETCH : IDLE;
    end

    always_comb begin
        ihit     = (r_state == IDLE) && w_hit && !flush;
        imemload = ((r_state == IDLE) && w_hit) ? r_data[w_index] : '0;
        iREN     = (r_state == FETCH);
        iaddr    = (r_state == FETCH) ? r_miss_addr : '0;
    end

    // Flush wins over a completing fill, so the filled set ends invalid.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)       r_valid <= '0;
        else if (flush)  r_valid <= '0;
        else if (w_fill) r_valid[w_fill_index] <= 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (w_fill) begin
            r_tag[w_fill_index]  <= w_fill_tag;
            r_data[w_fill_index] <= iload;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)       r_miss_addr <= '0;
        else if (w_miss) r_miss_addr <= {imemaddr[WORD_W-1:2], 2'b00};
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (ihit && hit_count != 32'hFFFF_FFFF)    hit_count  <= hit_count + 32'd1;
            if (w_miss && miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
        end
    end
`endif
endmodule
